// File: rtl/data_mem_resp.sv
// data_mem_resp: word-organised data RAM with post-reset clear and zero-latency read.
// Macro DMEM_MMIO_EN adds a GPIO/CYCLE/HALT window over the top four words.
module data_mem_resp #(
    parameter int n = 10,
    parameter int m = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] addr,
    input  logic [m-1:0] write_data,
    input  logic         memwr,
    output logic [m-1:0] read_data,
    output logic         ready,
    output logic [31:0]  gpio_out,
    output logic         halt,
    output logic [31:0]  halt_code
);
    localparam int DEPTH = 2 ** (n - 2);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state_q, state_d;
    logic [n-3:0] clr_idx_q, clr_idx_d;
    logic [m-1:0] mem [DEPTH];
    logic [n-3:0] widx, ram_idx;
    logic [m-1:0] ram_wd, mmio_rd;
    logic run, ram_we, mmio_hit;
    logic unused;

    assign unused = ^addr[1:0];
    assign widx = addr[n-1:2];
    assign run = state_q == RUN;
    assign ready = run;

    always_comb begin
        state_d = state_q;
        clr_idx_d = clr_idx_q;
        if (!run) begin
            clr_idx_d = clr_idx_q + {{(n-3){1'b0}}, 1'b1};
            state_d = &clr_idx_q ? RUN : CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Single write port: the clear sweep owns it until RUN, then the core's stores do.
    assign ram_we = !rst && (run ? memwr && !mmio_hit : 1'b1);
    assign ram_idx = run ? widx : clr_idx_q;
    assign ram_wd = run ? write_data : '0;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= ram_wd;
    end

    assign read_data = run ? (mmio_hit ? mmio_rd : mem[widx]) : '0;

`ifdef DMEM_MMIO_EN
    logic [31:0] gpio_q, gpio_d, cycle_q, cycle_d, code_q, code_d;
    logic halt_q, halt_d, wr;
    logic [1:0] sel;

    assign mmio_hit = &addr[n-1:4];
    assign sel = addr[3:2];
    assign wr = run && memwr && mmio_hit;

    always_comb begin
        gpio_d = (wr && sel == 2'd0) ? write_data : gpio_q;
        cycle_d = (wr && sel == 2'd1) ? write_data : (run && !halt_q) ? cycle_q + 32'd1 : cycle_q;
        halt_d = halt_q || (wr && sel == 2'd2);
        code_d = (wr && sel == 2'd2 && !halt_q) ? write_data : code_q;
        mmio_rd = sel == 2'd0 ? gpio_q : sel == 2'd1 ? cycle_q : sel == 2'd2 ? code_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_q <= '0;
            cycle_q <= '0;
            halt_q <= 1'b0;
            code_q <= '0;
        end else begin
            gpio_q <= gpio_d;
            cycle_q <= cycle_d;
            halt_q <= halt_d;
            code_q <= code_d;
        end
    end

    assign gpio_out = gpio_q;
    assign halt = halt_q;
    assign halt_code = code_q;
`else
    assign mmio_hit = 1'b0;
    assign mmio_rd = '0;
    assign gpio_out = '0;
    assign halt = 1'b0;
    assign halt_code = '0;
`endif
endmodule

// File: tb/tb_data_mem_resp.sv
// tb_data_mem_resp: directed self-checking bench for data_mem_resp (n=10, m=32).
module tb_data_mem_resp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  addr = '0;
    logic [31:0] write_data = '0;
    logic        memwr = 1'b0;
    logic [31:0] read_data, gpio_out, halt_code;
    logic        ready, halt;
    int errors = 0;
    int checks = 0;
`ifdef DMEM_MMIO_EN
    localparam int NW = 252;
`else
    localparam int NW = 256;
`endif

    data_mem_resp #(.n(10), .m(32)) dut (
        .clk(clk), .rst(rst), .addr(addr), .write_data(write_data), .memwr(memwr),
        .read_data(read_data), .ready(ready), .gpio_out(gpio_out), .halt(halt), .halt_code(halt_code)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 400) begin
            cyc();
            cnt++;
        end
    endtask

    task automatic store(input logic [9:0] a, input logic [31:0] d);
        addr = a;
        write_data = d;
        memwr = 1'b1;
        cyc();
        memwr = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        cyc();
        cyc();
        rst = 1'b0;
        wait_ready(cnt);
        for (int i = 0; i < 256; i++) store(10'(i * 4), 32'hA000_0000 | i);
        addr = 10'h014;
        #1;
        checks++;
        if (read_data !== 32'hA000_0005) begin
            errors++;
            $display("FAIL prefill got=%h exp=%h", read_data, 32'hA000_0005);
        end
        rst = 1'b1;
        cyc();
        checks++;
        if (ready !== 1'b0 || read_data !== 32'h0 || gpio_out !== 32'h0 || halt !== 1'b0 || halt_code !== 32'h0) begin
            errors++;
            $display("FAIL reset_state ready=%b rd=%h gpio=%h halt=%b code=%h exp all zero", ready, read_data, gpio_out, halt, halt_code);
        end
        rst = 1'b0;
        wait_ready(cnt);
        checks++;
        if (cnt !== 256) begin
            errors++;
            $display("FAIL clear_len got=%0d exp=256", cnt);
        end
        for (int i = 0; i < NW; i++) begin
            addr = 10'(i * 4);
            #1;
            checks++;
            if (read_data !== 32'h0) begin
                errors++;
                $display("FAIL cleared_word[%0d] got=%h exp=00000000", i, read_data);
            end
        end
    endtask

    task automatic test_store_load();
        addr = 10'h004;
        write_data = 32'hDEADBEEF;
        memwr = 1'b1;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL same_cycle got=%h exp=00000000", read_data);
        end
        cyc();
        memwr = 1'b0;
        #1;
        checks++;
        if (read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL next_cycle got=%h exp=deadbeef", read_data);
        end
        addr = 10'h007;
        #1;
        checks++;
        if (read_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL misaligned got=%h exp=deadbeef", read_data);
        end
    endtask

    task automatic test_clear_ignore();
        int cnt;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        addr = 10'h010;
        write_data = 32'h12345678;
        memwr = 1'b1;
        #1;
        checks++;
        if (read_data !== 32'h0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_read got=%h ready=%b exp=00000000 ready=0", read_data, ready);
        end
        wait_ready(cnt);
        memwr = 1'b0;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL clear_ignore got=%h exp=00000000", read_data);
        end
        addr = 10'h004;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL reclear got=%h exp=00000000", read_data);
        end
    endtask

    task automatic test_back_to_back();
        store(10'h020, 32'h1111_1111);
        store(10'h024, 32'h2222_2222);
        store(10'h028, 32'h3333_3333);
        store(10'h028, 32'h4444_4444);
        for (int i = 0; i < 3; i++) begin
            addr = 10'(32 + i * 4);
            #1;
            checks++;
            if (read_data !== (i == 2 ? 32'h4444_4444 : 32'h1111_1111 * (i + 1))) begin
                errors++;
                $display("FAIL b2b[%0d] got=%h", i, read_data);
            end
        end
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_cycle();
        logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
        store(10'h3F4, 32'hFFFF_FFFE);
        addr = 10'h3F4;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (read_data !== exp[i]) begin
                errors++;
                $display("FAIL cycle[%0d] got=%h exp=%h", i, read_data, exp[i]);
            end
            cyc();
        end
        store(10'h3F4, 32'h0000_0100);
        addr = 10'h3F4;
        #1;
        checks++;
        if (read_data !== 32'h0000_0100) begin
            errors++;
            $display("FAIL cycle_store got=%h exp=00000100", read_data);
        end
        cyc();
        checks++;
        if (read_data !== 32'h0000_0101) begin
            errors++;
            $display("FAIL cycle_inc got=%h exp=00000101", read_data);
        end
    endtask

    task automatic test_halt();
        logic [31:0] c0;
        store(10'h3F8, 32'h2A);
        store(10'h3F8, 32'h55);
        addr = 10'h3F8;
        #1;
        checks++;
        if (halt !== 1'b1 || halt_code !== 32'h2A || read_data !== 32'h2A) begin
            errors++;
            $display("FAIL halt halt=%b code=%h rd=%h exp=1 0000002a 0000002a", halt, halt_code, read_data);
        end
        addr = 10'h3F4;
        #1;
        c0 = read_data;
        cyc();
        cyc();
        checks++;
        if (read_data !== c0) begin
            errors++;
            $display("FAIL cycle_frozen got=%h exp=%h", read_data, c0);
        end
        store(10'h040, 32'hCAFE_F00D);
        addr = 10'h040;
        #1;
        checks++;
        if (read_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL ram_after_halt got=%h exp=cafef00d", read_data);
        end
    endtask

    task automatic test_gpio();
        store(10'h3F0, 32'h1234_ABCD);
        store(10'h3FC, 32'hFFFF_FFFF);
        addr = 10'h3F0;
        #1;
        checks++;
        if (gpio_out !== 32'h1234_ABCD || read_data !== 32'h1234_ABCD) begin
            errors++;
            $display("FAIL gpio out=%h rd=%h exp=1234abcd", gpio_out, read_data);
        end
        addr = 10'h3FC;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL reserved got=%h exp=00000000", read_data);
        end
    endtask
`else
    task automatic test_ram_top();
        store(10'h3F0, 32'hA5A5_A5A5);
        store(10'h3F8, 32'h0000_002A);
        addr = 10'h3F0;
        #1;
        checks++;
        if (read_data !== 32'hA5A5_A5A5 || gpio_out !== 32'h0) begin
            errors++;
            $display("FAIL ram_top rd=%h gpio=%h exp=a5a5a5a5 00000000", read_data, gpio_out);
        end
        addr = 10'h3F8;
        #1;
        checks++;
        if (read_data !== 32'h2A || halt !== 1'b0 || halt_code !== 32'h0) begin
            errors++;
            $display("FAIL ram_halt rd=%h halt=%b code=%h exp=0000002a 0 00000000", read_data, halt, halt_code);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_clear_ignore();
        test_back_to_back();
`ifdef DMEM_MMIO_EN
        test_cycle();
        test_gpio();
        test_halt();
`else
        test_ram_top();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
